fv_dup_scheduler: RTL and testbench

FV_DUP_SCHEDULER -- requirements
Module: fv_dup_scheduler

---
 rtl/fv_pkg.sv | 49 ++++
 rtl/fv_dup_replay_buf.sv | 28 ++
 rtl/fv_dup_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fv_dup_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_pkg.sv
// Shared types for the fetch/verify front end: instruction sizes, IF queue
// entries, replay buffer payload and the duplicate scheduler state encoding.
`ifndef FV_INSTR_WIDTH
`define FV_INSTR_WIDTH 32
`endif

package fv_pkg;

    localparam int INSTR_W = `FV_INSTR_WIDTH;

    typedef enum logic [1:0] {
        ISZ_NONE = 2'd0,
        ISZ_16   = 2'd1,
        ISZ_32   = 2'd2,
        ISZ_48   = 2'd3
    } instr_size_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        instr_size_t        instr_size;
        logic               pred_taken;
        logic               is_dup;
        logic               is_dup_flush;
        logic               is_dup_sync;
    } if_queue_entry_t;

    // Payload kept per original so its duplicate can be replayed later
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        instr_size_t        instr_size;
        logic               pred_taken;
    } replay_entry_t;

    typedef enum logic [1:0] {
        ST_ORIG      = 2'd0,
        ST_FLUSH_TOK = 2'd1,
        ST_DUP       = 2'd2,
        ST_SYNC_TOK  = 2'd3
    } dup_sched_state_t;

    function automatic if_queue_entry_t make_token(input logic flush_tok, input logic sync_tok);
        if_queue_entry_t t;
        t              = {$bits(if_queue_entry_t){1'b0}};
        t.is_dup_flush = flush_tok;
        t.is_dup_sync  = sync_tok;
        return t;
    endfunction

endpackage

// File: rtl/fv_dup_replay_buf.sv
// Replay buffer: DEPTH-entry register array, one write port, one
// combinational read port. Contents are not reset.
module fv_dup_replay_buf
    import fv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  replay_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output replay_entry_t rdata
);

    replay_entry_t mem_r [DEPTH];

    // Store one original per accepted transfer
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fv_dup_scheduler.sv
// Duplicate scheduler: passes originals straight through while recording them,
// then replays the batch as duplicates bracketed by flush and sync tokens.
module fv_dup_scheduler
    import fv_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter bit EMIT_FLUSH = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [`FV_INSTR_WIDTH-1:0]   in_instr,
    input  instr_size_t                  in_size,
    input  logic                         in_pred_taken,
    input  logic                         flush_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output if_queue_entry_t              out_entry,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   batch_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    dup_sched_state_t state_r;
    logic [CW-1:0]    batch_count_r;
    logic [AW-1:0]    rd_ptr_r;

    dup_sched_state_t eff_state_s;
    logic [CW-1:0]    eff_count_s;
    logic             xfer_s;
    logic [CW-1:0]    count_inc_s;
    logic             close_s;
    logic             last_s;
    logic             we_s;
    replay_entry_t    wr_entry_s;
    replay_entry_t    rd_entry_s;

    // While reset is held the outputs behave as an empty ORIG pass-through
    always_comb begin
        if (rst) begin
            eff_state_s = ST_ORIG;
            eff_count_s = {CW{1'b0}};
        end else begin
            eff_state_s = state_r;
            eff_count_s = batch_count_r;
        end
    end

    assign xfer_s      = in_valid & in_ready;
    assign count_inc_s = batch_count_r + {{(CW-1){1'b0}}, xfer_s};
    assign close_s     = (xfer_s && (count_inc_s == DEPTH_C)) ||
                         (flush_req && (count_inc_s != {CW{1'b0}}));
    assign last_s      = (CW'(rd_ptr_r) == (batch_count_r - CW'(1'b1)));
    assign we_s        = xfer_s & ~rst & (state_r == ST_ORIG);

    assign wr_entry_s.instr      = in_instr;
    assign wr_entry_s.instr_size = in_size;
    assign wr_entry_s.pred_taken = in_pred_taken;

    fv_dup_replay_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_replay_buf (
        .clk   (clk),
        .we    (we_s),
        .waddr (AW'(batch_count_r)),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Batch sequencing: collect originals, then flush token, duplicates, sync token
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_ORIG;
            batch_count_r <= {CW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_ORIG: begin
                    if (xfer_s) begin
                        batch_count_r <= count_inc_s;
                    end
                    if (close_s) begin
                        state_r  <= EMIT_FLUSH ? ST_FLUSH_TOK : ST_DUP;
                        rd_ptr_r <= {AW{1'b0}};
                    end
                end
                ST_FLUSH_TOK: begin
                    if (out_ready) begin
                        state_r <= ST_DUP;
                    end
                end
                ST_DUP: begin
                    if (out_ready) begin
                        if (last_s) begin
                            state_r <= ST_SYNC_TOK;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                        end
                    end
                end
                ST_SYNC_TOK: begin
                    if (out_ready) begin
                        state_r       <= ST_ORIG;
                        batch_count_r <= {CW{1'b0}};
                        rd_ptr_r      <= {AW{1'b0}};
                    end
                end
                default: begin
                    state_r       <= ST_ORIG;
                    batch_count_r <= {CW{1'b0}};
                    rd_ptr_r      <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Output mux; ORIG is deliberately zero-latency so originals are not delayed
    always_comb begin
        out_valid = 1'b0;
        out_entry = {$bits(if_queue_entry_t){1'b0}};
        in_ready  = 1'b0;
        case (eff_state_s)
            ST_ORIG: begin
                out_valid            = in_valid;
                out_entry.instr      = in_instr;
                out_entry.instr_size = in_size;
                out_entry.pred_taken = in_pred_taken;
                in_ready             = out_ready & (eff_count_s < DEPTH_C);
            end
            ST_FLUSH_TOK: begin
                out_valid = 1'b1;
                out_entry = make_token(1'b1, 1'b0);
            end
            ST_DUP: begin
                out_valid            = 1'b1;
                out_entry.instr      = rd_entry_s.instr;
                out_entry.instr_size = rd_entry_s.instr_size;
                out_entry.pred_taken = rd_entry_s.pred_taken;
                out_entry.is_dup     = 1'b1;
            end
            ST_SYNC_TOK: begin
                out_valid = 1'b1;
                out_entry = make_token(1'b0, 1'b1);
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign busy        = (eff_state_s != ST_ORIG);
    assign batch_count = eff_count_s;

endmodule

// File: tb/tb_fv_dup_scheduler.sv
// Bench for fv_dup_scheduler: two configurations driven in parallel and
// compared every cycle against a queue-based model of the batch/replay rules.
module tb_fv_dup_scheduler;
    import fv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic [31:0]     in_instr;
    instr_size_t     in_size;
    logic            in_pred_taken;
    logic            flush_req;
    logic            out_ready;

    logic            in_ready_a, out_valid_a, busy_a;
    if_queue_entry_t out_entry_a;
    logic [3:0]      batch_count_a;
    logic            in_ready_b, out_valid_b, busy_b;
    if_queue_entry_t out_entry_b;
    logic [2:0]      batch_count_b;

    fv_dup_scheduler #(.DEPTH(8), .EMIT_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_size(in_size), .in_pred_taken(in_pred_taken),
        .flush_req(flush_req), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_entry(out_entry_a), .busy(busy_a), .batch_count(batch_count_a)
    );

    fv_dup_scheduler #(.DEPTH(4), .EMIT_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_size(in_size), .in_pred_taken(in_pred_taken),
        .flush_req(flush_req), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_entry(out_entry_b), .busy(busy_b), .batch_count(batch_count_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: held originals per DUT, plus a pending output sequence once a batch closes
    if_queue_entry_t m_batch [2][32];
    int              m_bsz   [2];
    if_queue_entry_t m_pend  [2][80];
    int              m_ph    [2];
    int              m_pt    [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic if_queue_entry_t tb_token(input bit f, input bit s);
        if_queue_entry_t t;
        t = '0;
        t.is_dup_flush = f;
        t.is_dup_sync  = s;
        return t;
    endfunction

    function automatic if_queue_entry_t cur_input();
        if_queue_entry_t t;
        t = '0;
        t.instr      = in_instr;
        t.instr_size = in_size;
        t.pred_taken = in_pred_taken;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input instr_size_t sz,
                         input logic pt, input logic fl, input logic ordy, input logic r);
        @(negedge clk);
        in_valid = v; in_instr = ins; in_size = sz; in_pred_taken = pt;
        flush_req = fl; out_ready = ordy; rst = r;
        #1;
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            int depth; bit emit; bit orig; string p;
            logic ov, ir, bz; if_queue_entry_t oe; int bc;
            logic e_ov, e_ir, e_bz; if_queue_entry_t e_oe; int e_bc;
            depth = (i == 0) ? 8 : 4;
            emit  = (i == 0);
            p     = (i == 0) ? "a" : "b";
            if (i == 0) begin
                ov = out_valid_a; ir = in_ready_a; bz = busy_a; oe = out_entry_a; bc = int'(batch_count_a);
            end else begin
                ov = out_valid_b; ir = in_ready_b; bz = busy_b; oe = out_entry_b; bc = int'(batch_count_b);
            end
            orig = rst || (m_ph[i] == m_pt[i]);
            if (orig) begin
                e_bc = rst ? 0 : m_bsz[i];
                e_ov = in_valid;
                e_oe = cur_input();
                e_ir = out_ready && (e_bc < depth);
                e_bz = 1'b0;
            end else begin
                e_bc = m_bsz[i];
                e_ov = 1'b1;
                e_oe = m_pend[i][m_ph[i]];
                e_ir = 1'b0;
                e_bz = 1'b1;
            end
            chk($sformatf("%s_out_valid", p),   64'(ov), 64'(e_ov));
            chk($sformatf("%s_out_entry", p),   64'(oe), 64'(e_oe));
            chk($sformatf("%s_in_ready", p),    64'(ir), 64'(e_ir));
            chk($sformatf("%s_busy", p),        64'(bz), 64'(e_bz));
            chk($sformatf("%s_batch_count", p), 64'(bc), 64'(e_bc));
            if (rst) begin
                m_bsz[i] = 0; m_ph[i] = 0; m_pt[i] = 0;
            end else if (orig) begin
                if (in_valid && e_ir) begin
                    m_batch[i][m_bsz[i]] = cur_input();
                    m_bsz[i]++;
                end
                if ((in_valid && e_ir && m_bsz[i] == depth) || (flush_req && m_bsz[i] > 0)) begin
                    m_ph[i] = 0; m_pt[i] = 0;
                    if (emit) begin
                        m_pend[i][m_pt[i]] = tb_token(1'b1, 1'b0); m_pt[i]++;
                    end
                    for (int k = 0; k < m_bsz[i]; k++) begin
                        m_pend[i][m_pt[i]] = m_batch[i][k];
                        m_pend[i][m_pt[i]].is_dup = 1'b1;
                        m_pt[i]++;
                    end
                    m_pend[i][m_pt[i]] = tb_token(1'b0, 1'b1); m_pt[i]++;
                end
            end else if (out_ready) begin
                if (m_pend[i][m_ph[i]].is_dup_sync) begin
                    m_bsz[i] = 0; m_ph[i] = 0; m_pt[i] = 0;
                end else begin
                    m_ph[i]++;
                end
            end
        end
    endtask

    task automatic tick(input logic v, input logic [31:0] ins, input logic fl,
                        input logic ordy, input logic r);
        drive(v, ins, ISZ_32, ins[0], fl, ordy, r);
        model_check();
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (m_ph[0] == m_pt[0] && m_ph[1] == m_pt[1]) break;
            tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        m_bsz = '{0, 0}; m_ph = '{0, 0}; m_pt = '{0, 0};
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_size = ISZ_NONE;
        in_pred_taken = 1'b0; flush_req = 1'b0; out_ready = 1'b1;

        // reset, with an original offered to show pass-through under reset
        tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 32'h99, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_count_a", 64'(batch_count_a), 64'd0);
        chk("reset_busy_a", 64'(busy_a), 64'd0);
        model_check();

        // full batch of 8
        for (int k = 0; k < 8; k++) tick(1'b1, 32'h11 + k, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_flush_tok_a", 64'(out_entry_a), 64'(tb_token(1'b1, 1'b0)));
        chk("full_busy_a", 64'(busy_a), 64'd1);
        model_check();
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_dup1_instr_a", 64'(out_entry_a.instr), 64'h11);
        chk("full_dup1_flag_a", 64'(out_entry_a.is_dup), 64'd1);
        model_check();
        drain();
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_idle_busy_a", 64'(busy_a), 64'd0);
        model_check();

        // early flush together with the 4th original
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h21 + k, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 32'h24, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush4_count_a", 64'(batch_count_a), 64'd4);
        model_check();
        drain();

        // backpressure during duplicates
        for (int k = 0; k < 6; k++) tick(1'b1, 32'h31 + k, (k == 5), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h77, ISZ_16, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stall_in_ready_a", 64'(in_ready_a), 64'd0);
            model_check();
        end
        drain();

        // no flush token when disabled
        tick(1'b1, 32'h41, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 32'h42, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("noflush_dup_b", 64'(out_entry_b.is_dup), 64'd1);
        chk("noflush_tok_b", 64'(out_entry_b.is_dup_flush), 64'd0);
        model_check();
        drain();

        // reset in the middle of replaying a 5-entry batch
        for (int k = 0; k < 5; k++) tick(1'b1, 32'h51 + k, (k == 4), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("midrst_count_a", 64'(batch_count_a), 64'd0);
        chk("midrst_busy_a", 64'(busy_a), 64'd0);
        model_check();
        drive(1'b1, 32'h55, ISZ_32, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("midrst_pass_valid_a", 64'(out_valid_a), 64'd1);
        chk("midrst_pass_instr_a", 64'(out_entry_a.instr), 64'h55);
        chk("midrst_pass_dup_a", 64'(out_entry_a.is_dup), 64'd0);
        model_check();
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        drain();

        // flush with nothing buffered
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, ISZ_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_flush_busy_a", 64'(busy_a), 64'd0);
        chk("empty_flush_busy_b", 64'(busy_b), 64'd0);
        chk("empty_flush_valid_a", 64'(out_valid_a), 64'd0);
        model_check();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, instr_size_t'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
            model_check();
        end
        tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
